sdram_arbiter: RTL and testbench

Three-port SDRAM access arbiter in the fpgagen core. It sits between the SDRAM command controller and three requesters: the ROM download path from data_io, the 68k CPU bus and the VDP DMA/fetch path. It serialises their single-word accesses through one req/ack handshake each. Priority is fixed, with optional CPU anti-starvation aging.

---
 rtl/sdram_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_sdram_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// Three-port SDRAM access arbiter: download, VDP and CPU requesters share one controller.
// Fixed priority dl > vdp > cpu. Define SDRAM_ARB_AGING_EN to promote a starved CPU over the VDP.
module sdram_arbiter #(
    parameter int AW       = 24,
    parameter int DW       = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset_n,

    input  logic          dl_req,
    input  logic [AW-1:0] dl_addr,
    input  logic [DW-1:0] dl_din,
    output logic          dl_ack,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [1:0]    cpu_be,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_din,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_dout,

    input  logic          vdp_req,
    input  logic [AW-1:0] vdp_addr,
    output logic          vdp_ack,
    output logic [DW-1:0] vdp_dout,

    output logic          mem_start,
    output logic          mem_we,
    output logic [1:0]    mem_be,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic          mem_done,
    input  logic [DW-1:0] mem_dout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        GR_DL  = 2'd0,
        GR_CPU = 2'd1,
        GR_VDP = 2'd2
    } grant_t;

    state_t state_r;
    state_t state_nxt_s;
    grant_t grant_r;
    grant_t winner_s;
    logic   any_req_s;
    logic   accept_s;
    logic   cpu_promote_s;

    assign any_req_s = dl_req | cpu_req | vdp_req;
    assign accept_s  = (state_r == ST_IDLE) && any_req_s;

`ifdef SDRAM_ARB_AGING_EN
    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    logic [3:0] cpu_wait_r;

    assign cpu_promote_s = cpu_req && (cpu_wait_r == MAX_WAIT_C);

    // Count VDP grants that overtook a waiting CPU; a CPU grant clears the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpu_wait_r <= 4'd0;
        end else if (accept_s) begin
            if (winner_s == GR_CPU) begin
                cpu_wait_r <= 4'd0;
            end else if ((winner_s == GR_VDP) && cpu_req && (cpu_wait_r != MAX_WAIT_C)) begin
                cpu_wait_r <= cpu_wait_r + 4'd1;
            end else begin
                cpu_wait_r <= cpu_wait_r;
            end
        end else begin
            cpu_wait_r <= cpu_wait_r;
        end
    end
`else
    assign cpu_promote_s = 1'b0;
`endif

    // Winner selection; only meaningful in IDLE when some request is present.
    always_comb begin
        winner_s = GR_DL;
        if (dl_req) begin
            winner_s = GR_DL;
        end else if (cpu_promote_s) begin
            winner_s = GR_CPU;
        end else if (vdp_req) begin
            winner_s = GR_VDP;
        end else if (cpu_req) begin
            winner_s = GR_CPU;
        end else begin
            winner_s = GR_DL;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_nxt_s = ST_START;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: state_nxt_s = ST_WAIT;
            ST_WAIT: begin
                if (mem_done) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_RESP: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Command attributes latched on grant; start strobe high during START.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_r   <= GR_DL;
            mem_start <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 2'b00;
            mem_addr  <= {AW{1'b0}};
            mem_din   <= {DW{1'b0}};
        end else begin
            mem_start <= accept_s;
            if (accept_s) begin
                grant_r <= winner_s;
                case (winner_s)
                    GR_DL: begin
                        mem_we   <= 1'b1;
                        mem_be   <= 2'b11;
                        mem_addr <= dl_addr;
                        mem_din  <= dl_din;
                    end
                    GR_CPU: begin
                        mem_we   <= cpu_we;
                        mem_be   <= cpu_be;
                        mem_addr <= cpu_addr;
                        mem_din  <= cpu_din;
                    end
                    GR_VDP: begin
                        mem_we   <= 1'b0;
                        mem_be   <= 2'b11;
                        mem_addr <= vdp_addr;
                        mem_din  <= {DW{1'b0}};
                    end
                    default: begin
                        mem_we   <= 1'b0;
                        mem_be   <= 2'b00;
                        mem_addr <= {AW{1'b0}};
                        mem_din  <= {DW{1'b0}};
                    end
                endcase
            end
        end
    end

    // Completion: ack pulses in RESP, read data captured on the granted port only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dl_ack   <= 1'b0;
            cpu_ack  <= 1'b0;
            vdp_ack  <= 1'b0;
            cpu_dout <= {DW{1'b0}};
            vdp_dout <= {DW{1'b0}};
        end else begin
            dl_ack  <= 1'b0;
            cpu_ack <= 1'b0;
            vdp_ack <= 1'b0;
            if ((state_r == ST_WAIT) && mem_done) begin
                case (grant_r)
                    GR_DL: dl_ack <= 1'b1;
                    GR_CPU: begin
                        cpu_ack <= 1'b1;
                        if (!mem_we) begin
                            cpu_dout <= mem_dout;
                        end
                    end
                    GR_VDP: begin
                        vdp_ack  <= 1'b1;
                        vdp_dout <= mem_dout;
                    end
                    default: dl_ack <= 1'b0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed self-checking bench for sdram_arbiter; expectations follow SDRAM_ARB_AGING_EN if defined.
module tb_sdram_arbiter;

    localparam int AW = 24;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          dl_req, cpu_req, cpu_we, vdp_req;
    logic [AW-1:0] dl_addr, cpu_addr, vdp_addr;
    logic [DW-1:0] dl_din, cpu_din;
    logic [1:0]    cpu_be;
    logic          dl_ack, cpu_ack, vdp_ack;
    logic [DW-1:0] cpu_dout, vdp_dout;
    logic          mem_start, mem_we, mem_done;
    logic [1:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din, mem_dout;

    int checks = 0;
    int errors = 0;

    logic          got_s;
    logic [AW-1:0] s_addr;
    logic          s_we;
    logic [1:0]    s_be;
    logic [DW-1:0] s_din;
    logic [AW-1:0] exp_addr;

    sdram_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .dl_req(dl_req), .dl_addr(dl_addr), .dl_din(dl_din), .dl_ack(dl_ack),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
        .cpu_din(cpu_din), .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
        .vdp_req(vdp_req), .vdp_addr(vdp_addr), .vdp_ack(vdp_ack), .vdp_dout(vdp_dout),
        .mem_start(mem_start), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_done(mem_done), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Controller model: wait (bounded) for mem_start, answer n cycles later, return in the ack cycle.
    task automatic serve(input int n, input logic [DW-1:0] data,
                         output logic got, output logic [AW-1:0] a, output logic w,
                         output logic [1:0] b, output logic [DW-1:0] d);
        int i = 0;
        while (!mem_start && i < 8) begin
            tick();
            i++;
        end
        got = mem_start;
        a = mem_addr; w = mem_we; b = mem_be; d = mem_din;
        for (int j = 0; j < n; j++) tick();
        mem_done = 1'b1;
        mem_dout = data;
        tick();
        mem_done = 1'b0;
        mem_dout = 16'h0000;
    endtask

    initial begin
        reset_n = 1'b0;
        dl_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; vdp_req = 1'b0;
        dl_addr = 24'h0; cpu_addr = 24'h0; vdp_addr = 24'h0;
        dl_din = 16'h0; cpu_din = 16'h0; cpu_be = 2'b00;
        mem_done = 1'b0; mem_dout = 16'h0;
        tick(); tick();
        chk("rst_start", {31'd0, mem_start}, 32'd0);
        chk("rst_acks", {29'd0, dl_ack, cpu_ack, vdp_ack}, 32'd0);
        chk("rst_attr", {5'd0, mem_we, mem_be, mem_addr}, 32'd0);
        chk("rst_dout", {cpu_dout, vdp_dout}, 32'd0);
        reset_n = 1'b1;
        tick();

        // Stray mem_done in IDLE must be ignored.
        mem_done = 1'b1; mem_dout = 16'h1234;
        tick();
        mem_done = 1'b0; mem_dout = 16'h0;
        chk("stray_done_ack", {29'd0, dl_ack, cpu_ack, vdp_ack}, 32'd0);
        chk("stray_done_dout", {16'd0, cpu_dout}, 32'd0);

        // Single CPU read with controller latency n=2.
        cpu_req = 1'b1; cpu_addr = 24'h000123; cpu_we = 1'b0; cpu_be = 2'b11;
        tick();
        chk("rd_start", {31'd0, mem_start}, 32'd1);
        chk("rd_addr", {8'd0, mem_addr}, 32'h000123);
        chk("rd_we", {31'd0, mem_we}, 32'd0);
        tick();
        chk("rd_start_pulse", {31'd0, mem_start}, 32'd0);
        tick();
        chk("rd_early_ack", {31'd0, cpu_ack}, 32'd0);
        mem_done = 1'b1; mem_dout = 16'hBEEF;
        tick();
        mem_done = 1'b0; mem_dout = 16'h0;
        chk("rd_ack", {29'd0, dl_ack, cpu_ack, vdp_ack}, 32'b010);
        chk("rd_dout", {16'd0, cpu_dout}, 32'h0000BEEF);
        cpu_req = 1'b0;
        tick();
        chk("rd_ack_pulse", {31'd0, cpu_ack}, 32'd0);

        // Simultaneous requests: dl, then vdp, then cpu.
        dl_req = 1'b1; dl_addr = 24'h000100; dl_din = 16'h5555;
        vdp_req = 1'b1; vdp_addr = 24'h000200;
        cpu_req = 1'b1; cpu_addr = 24'h000300; cpu_we = 1'b0; cpu_be = 2'b11;
        serve(1, 16'h1111, got_s, s_addr, s_we, s_be, s_din);
        chk("m1_got", {31'd0, got_s}, 32'd1);
        chk("m1_addr", {8'd0, s_addr}, 32'h000100);
        chk("m1_wbd", {13'd0, s_we, s_be, s_din}, {13'd0, 1'b1, 2'b11, 16'h5555});
        chk("m1_acks", {29'd0, dl_ack, cpu_ack, vdp_ack}, 32'b100);
        dl_req = 1'b0;
        serve(1, 16'h2222, got_s, s_addr, s_we, s_be, s_din);
        chk("m2_addr", {7'd0, got_s, s_addr}, {7'd0, 1'b1, 24'h000200});
        chk("m2_wb", {29'd0, s_we, s_be}, {29'd0, 1'b0, 2'b11});
        chk("m2_acks", {29'd0, dl_ack, cpu_ack, vdp_ack}, 32'b001);
        chk("m2_dout", {16'd0, vdp_dout}, 32'h00002222);
        vdp_req = 1'b0;
        serve(1, 16'h3333, got_s, s_addr, s_we, s_be, s_din);
        chk("m3_addr", {7'd0, got_s, s_addr}, {7'd0, 1'b1, 24'h000300});
        chk("m3_acks", {29'd0, dl_ack, cpu_ack, vdp_ack}, 32'b010);
        chk("m3_dout", {16'd0, cpu_dout}, 32'h00003333);
        cpu_req = 1'b0;
        tick();
        chk("m_idle_acks", {29'd0, dl_ack, cpu_ack, vdp_ack}, 32'd0);

        // CPU byte write: dout must keep the last read value.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 2'b01; cpu_din = 16'h00AA; cpu_addr = 24'h000310;
        serve(1, 16'h7777, got_s, s_addr, s_we, s_be, s_din);
        chk("wr_addr", {7'd0, got_s, s_addr}, {7'd0, 1'b1, 24'h000310});
        chk("wr_wbd", {13'd0, s_we, s_be, s_din}, {13'd0, 1'b1, 2'b01, 16'h00AA});
        chk("wr_acks", {29'd0, dl_ack, cpu_ack, vdp_ack}, 32'b010);
        chk("wr_dout_kept", {16'd0, cpu_dout}, 32'h00003333);
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_be = 2'b11;
        tick();

        // VDP and CPU both held high: aging decides whether the CPU ever gets in.
        vdp_req = 1'b1; vdp_addr = 24'h000200;
        cpu_req = 1'b1; cpu_addr = 24'h000300;
        for (int k = 0; k < 10; k++) begin
            serve(1, 16'h4000 + 16'(k), got_s, s_addr, s_we, s_be, s_din);
`ifdef SDRAM_ARB_AGING_EN
            exp_addr = (k == 4 || k == 9) ? 24'h000300 : 24'h000200;
`else
            exp_addr = 24'h000200;
`endif
            chk($sformatf("age_grant%0d", k), {7'd0, got_s, s_addr}, {7'd0, 1'b1, exp_addr});
        end
        vdp_req = 1'b0; cpu_req = 1'b0;
        tick(); tick();

        // Reset asserted while waiting on the controller.
        cpu_req = 1'b1; cpu_addr = 24'h000400; cpu_we = 1'b0;
        tick();
        chk("rw_start", {31'd0, mem_start}, 32'd1);
        tick();
        reset_n = 1'b0;
        #1;
        chk("rw_outs", {4'd0, mem_start, dl_ack, cpu_ack, vdp_ack, mem_we, mem_be, mem_addr}, 32'd0);
        chk("rw_douts", {cpu_dout, vdp_dout}, 32'd0);
        chk("rw_din", {16'd0, mem_din}, 32'd0);
        tick();
        chk("rw_held", {28'd0, mem_start, dl_ack, cpu_ack, vdp_ack}, 32'd0);
        reset_n = 1'b1;
        tick();
        chk("rw_restart", {7'd0, mem_start, mem_addr}, {7'd0, 1'b1, 24'h000400});
        serve(1, 16'hCAFE, got_s, s_addr, s_we, s_be, s_din);
        chk("rw_acks", {29'd0, dl_ack, cpu_ack, vdp_ack}, 32'b010);
        chk("rw_dout", {16'd0, cpu_dout}, 32'h0000CAFE);
        cpu_req = 1'b0;
        tick();
        chk("end_acks", {29'd0, dl_ack, cpu_ack, vdp_ack}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
